// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead add/sub, one BLOCK-bit group resolved per stage
// Optional: define CLA_PIPE_SAT_EN to clamp the sum to the signed limit on overflow.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    if ((BLOCK != 4 && BLOCK != 8) || (WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_param_check
        $error("cla_pipe_addsub: BLOCK must be 4 or 8 and WIDTH a multiple of BLOCK");
    end

    // Every carry is a flat sum of products over the group's P/G terms, no ripple.
    function automatic logic [BLOCK:0] lookahead(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             c0
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            term = c0;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * BLOCK;
        localparam int DONE = (k + 1) * BLOCK;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] s;
        logic [BLOCK:0]   c;
        logic [DONE-1:0]  res;

        // Stage 0 conditions operands at accept; later stages take the skewed operands.
        if (k == 0) begin : g_in
            assign a_in = a;
            assign b_in = sub ? ~b : b;
            assign c_in = cin ^ sub;
            assign v_in = in_valid && in_ready;
            assign res  = s;
        end else begin : g_in
            assign a_in = g_stage[k-1].g_reg.opa_q;
            assign b_in = g_stage[k-1].g_reg.opb_q;
            assign c_in = g_stage[k-1].g_reg.cy_q;
            assign v_in = g_stage[k-1].g_reg.vld_q;
            assign res  = {s, g_stage[k-1].g_reg.res_q};
        end

        always_comb begin
            p = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
            g = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
            c = lookahead(p, g, c_in);
            s = p ^ c[BLOCK-1:0];
        end

        if (k < LAST) begin : g_reg
            logic                 vld_q, vld_d;
            logic                 cy_q, cy_d;
            logic [REM-BLOCK-1:0] opa_q, opa_d;
            logic [REM-BLOCK-1:0] opb_q, opb_d;
            logic [DONE-1:0]      res_q, res_d;

            always_comb begin
                vld_d = v_in;
                cy_d  = c[BLOCK];
                opa_d = a_in[REM-1:BLOCK];
                opb_d = b_in[REM-1:BLOCK];
                res_d = res;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    opa_q <= '0;
                    opb_q <= '0;
                    res_q <= '0;
                end else if (advance) begin
                    vld_q <= vld_d;
                    cy_q  <= cy_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    res_q <= res_d;
                end
            end
        end else begin : g_last
            logic             vld_q, vld_d;
            logic             cout_q, cout_d;
            logic             ovf_q, ovf_d;
            logic             zero_q, zero_d;
            logic [WIDTH-1:0] sum_q, sum_d;

            always_comb begin
                vld_d  = v_in;
                cout_d = c[BLOCK];
                ovf_d  = c[BLOCK] ^ c[BLOCK-1];
                sum_d  = res;
`ifdef CLA_PIPE_SAT_EN
                // On overflow both operands share a sign, so A's MSB gives the true sign.
                if (ovf_d) begin
                    sum_d = a_in[REM-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                zero_d = (sum_d == '0);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                    sum_q  <= '0;
                end else if (advance) begin
                    vld_q  <= vld_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                    sum_q  <= sum_d;
                end
            end

            assign out_valid = vld_q;
            assign sum       = sum_q;
            assign cout      = cout_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - directed bench for cla_pipe_addsub (32/8) plus an 8/4 sweep
module tb_cla_pipe_addsub;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NV = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf, w_zero;
    logic [7:0]  w_a, w_b, w_sum;

    int total = 0;
    int bad   = 0;

    cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.WIDTH(8), .BLOCK(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, input logic ts, input logic [31:0] esum,
                           input logic ecout, input logic eovf, input logic ezero);
        int lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_flags"}, {cout, ovf, zero}, {ecout, eovf, ezero});
    endtask

    // Independent integer model of the 8-bit unit: {sum, cout, ovf, zero}.
    function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y,
                                           input logic c, input logic s);
        int          sx, sy, sr;
        int unsigned ux, uy;
        logic [7:0]  r;
        logic        co, ov;
        sx = $signed(x); sy = $signed(y); ux = x; uy = y;
        if (s) begin
            sr = sx - sy - int'(c);
            co = (ux >= uy + c);
        end else begin
            sr = sx + sy + int'(c);
            co = (ux + uy + c) > 255;
        end
        ov = (sr > 127) || (sr < -128);
        r  = sr[7:0];
        if (SAT && ov) r = (sr > 0) ? 8'h7F : 8'h80;
        return {r, co, ov, (r == 8'h00)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx_in, idx_out, seen, sent, got;
        logic        pending;
        logic [7:0]  va, vb;
        logic        vc, vs;
        logic [7:0]  cv [4];
        logic [10:0] expq [$];

        rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
        w_in_valid = 0; w_a = 0; w_b = 0; w_cin = 0; w_sub = 0; w_out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1);

        run_one("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1);
        run_one("povf",   32'h7FFF_FFFF, 32'h0000_0001, 0, 0,
                SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1, 0);
        run_one("sub57",  32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        run_one("novf",   32'h8000_0000, 32'h0000_0001, 0, 1,
                SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1, 0);
        run_one("sub103", 32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0006, 1, 0, 0);
        run_one("addcin", 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 32'hACF1_3569, 0, 0, 0);

        // Stream of 8 with a 5-cycle downstream stall starting at cycle 5.
        idx_in = 0; idx_out = 0;
        for (int cyc = 0; cyc < 80 && idx_out < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 10);
            in_valid  = (idx_in < 8);
            a = 32'h00FF_FFFF; b = idx_in + 1; cin = 0; sub = 0;
            #1;
            if (!out_ready) begin
                chk("hold_in_ready", in_ready, 0);
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum, 32'h0100_0000 + idx_out);
            end else if (out_valid) begin
                chk("stream_sum", sum, 32'h0100_0000 + idx_out);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        chk("stream_count", idx_out, 8);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("stream_no_dup", seen, 0);

        // Reset with one result at the output and three operations in flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1; a = 2 * i + 1; b = 2 * i + 2; cin = 0; sub = 0;
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_sum", sum, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_flags", {cout, ovf, zero}, 0);
        chk("async_rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", in_ready, 1);
        run_one("after_rst", 32'h1, 32'h1, 0, 0, 32'h2, 0, 0, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_discard", seen, 0);

        // 8-bit / 4-bit-group sweep: corners first, then random, random backpressure.
        cv[0] = 8'h00; cv[1] = 8'h7F; cv[2] = 8'h80; cv[3] = 8'hFF;
        sent = 0; got = 0; pending = 0; va = 0; vb = 0; vc = 0; vs = 0;
        for (int cyc = 0; cyc < 30000 && got < NV; cyc++) begin
            @(negedge clk);
            if (!pending && sent < NV) begin
                if (sent < 64) begin
                    va = cv[sent % 4]; vb = cv[(sent / 4) % 4];
                    vc = 1'((sent / 16) % 2); vs = 1'((sent / 32) % 2);
                end else begin
                    va = 8'($urandom); vb = 8'($urandom);
                    vc = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
                end
                pending = 1;
            end
            w_a = va; w_b = vb; w_cin = vc; w_sub = vs;
            w_in_valid  = pending && ($urandom_range(0, 4) != 0);
            w_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (w_out_valid && w_out_ready) begin
                if (expq.size() == 0) chk("sweep_extra", 1, 0);
                else chk("sweep", {w_sum, w_cout, w_ovf, w_zero}, expq.pop_front());
                got++;
            end
            if (w_in_valid && w_in_ready) begin
                expq.push_back(model8(va, vb, vc, vs));
                pending = 0;
                sent++;
            end
        end
        chk("sweep_count", got, NV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
